// File: rtl/signed_mult32.sv
// Sequential 32x32 signed multiplier using radix-2 Booth recoding, one iteration per clock.
// Latency 32 edges from accept to product; start is ignored while busy; done pulses one cycle per result.
module signed_mult32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last_iter;

    // One extra accumulator bit keeps acc - (-2^31) representable.
    logic [WIDTH:0]  acc;
    logic [WIDTH:0]  mcand;
    logic [WIDTH:0]  sum;
    logic [WIDTH-1:0] q;
    logic            q_m1;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        accept    = (state == IDLE) && start;
        last_iter = (state == RUN) && (cnt == LAST);
    end

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= last_iter;
            if (accept) begin
                mcand <= {a[WIDTH-1], a};
                acc   <= '0;
                q     <= b;
                q_m1  <= 1'b0;
                cnt   <= '0;
            end else if (state == RUN) begin
                acc  <= {sum[WIDTH], sum[WIDTH:1]};
                q    <= {sum[0], q[WIDTH-1:1]};
                q_m1 <= q[0];
                cnt  <= cnt + 1'b1;
                if (last_iter) begin
                    product <= {sum[WIDTH:1], sum[0], q[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_mult32.sv
// Self-checking bench for signed_mult32: cycle model plus expected-product queue.
module tb_signed_mult32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    signed_mult32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          busy_cycles = 0;
    int          done_count = 0;
    int          last_done = -1;
    bit          mon_en = 1'b0;
    bit          reg_mode = 1'b0;

    // Reference cycle model, updated once per cycle from the inputs seen by the next edge.
    bit          m_run = 1'b0;
    int          m_cnt = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            check("busy", {63'd0, busy}, {63'd0, m_run});
            check("done", {63'd0, done}, {63'd0, m_done});
            check("product", product, m_prod);
            if (busy) busy_cycles++;
            if (done) begin
                if (reg_mode && last_done >= 0)
                    check("done_spacing", 64'(cyc - last_done), 64'd33);
                last_done = cyc;
                done_count++;
            end
        end
        if (rst) begin
            m_run  = 1'b0;
            m_cnt  = 0;
            m_done = 1'b0;
            m_prod = '0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_run) begin
                m_cnt++;
                if (m_cnt == 32) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_prod = exp_q.pop_front();
                end
            end else if (start) begin
                exp_q.push_back(ref_mul(a, b));
                m_run = 1'b1;
                m_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (33) tick();
    endtask

    logic [31:0] ext_a [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] ext_b [4] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [63:0] ext_p [4] = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
                               64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000};

    initial begin
        int guard;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        check("reset_product", product, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        repeat (10) tick();
        check("idle_product", product, 64'd0);
        check("idle_dones", 64'(done_count), 64'd0);

        busy_cycles = 0;
        done_count = 0;
        run_op(32'hFFFF_FFFB, 32'h0000_0004);
        check("neg_product", product, 64'hFFFF_FFFF_FFFF_FFEC);
        check("neg_busy_cycles", 64'(busy_cycles), 64'd32);
        check("neg_dones", 64'(done_count), 64'd1);

        for (int i = 0; i < 4; i++) begin
            run_op(ext_a[i], ext_b[i]);
            check("extreme_product", product, ext_p[i]);
        end

        done_count = 0;
        a = 32'd3;
        b = 32'hFFFF_FFF9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        a = 32'd1000;
        b = 32'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("busy_prot_product", product, 64'hFFFF_FFFF_FFFF_FFEB);
        check("busy_prot_dones", 64'(done_count), 64'd1);

        done_count = 0;
        a = 32'd100;
        b = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_product", product, 64'd0);
        repeat (35) tick();
        check("abort_dones", 64'(done_count), 64'd0);
        run_op(32'd100, 32'd100);
        check("after_abort_product", product, 64'h0000_0000_0000_2710);

        reg_mode = 1'b1;
        last_done = -1;
        done_count = 0;
        guard = 0;
        start = 1'b1;
        while (done_count < 1000 && guard < 34000) begin
            a = $urandom;
            b = $urandom;
            tick();
            guard++;
        end
        start = 1'b0;
        repeat (40) tick();
        check("reg_done_count", {63'd0, done_count >= 1000}, 64'd1);
        check("reg_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
